// File: rtl/ring_evt_pkg.sv
// Shared types and constants for the DAQ ring event buffer.
// l1a_ent_t is the default-width FIFO entry; the top re-declares it at its own widths.
package ring_evt_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HDR  = 2'd1,
        READ = 2'd2
    } rd_state_e;

    localparam int RD_LAT     = 2;
    localparam int DEF_ADDR_W = 12;
    localparam int DEF_TAG_W  = 24;

    typedef struct packed {
        logic [DEF_ADDR_W-1:0] start;
        logic [DEF_TAG_W-1:0]  tag;
    } l1a_ent_t;

    // A zero sample count still produces one word so every event carries EVT_LAST.
    function automatic logic [6:0] eff_nsamp(input logic [6:0] n);
        return (n == 7'd0) ? 7'd1 : n;
    endfunction

endpackage

// File: rtl/ring_l1a_fifo.sv
// Synchronous FIFO holding pending L1A entries; head is first-word-fall-through.
// Pushes while full and pops while empty are ignored.
module ring_l1a_fifo
    import ring_evt_pkg::*;
#(
    parameter int W  = 36,
    parameter int AW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic [W-1:0]  din,
    output logic [W-1:0]  dout,
    output logic [AW:0]   count,
    output logic          full,
    output logic          empty
);

    localparam int DEPTH = 2**AW;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic          push_ok, pop_ok;

    always_comb begin
        full    = (cnt_q == (AW+1)'(DEPTH));
        empty   = (cnt_q == '0);
        push_ok = push && !full;
        pop_ok  = pop && !empty;
        wptr_d  = push_ok ? wptr_q + AW'(1) : wptr_q;
        rptr_d  = pop_ok ? rptr_q + AW'(1) : rptr_q;
        cnt_d   = cnt_q + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wptr_q] <= din;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
        end
    end

    assign dout  = mem[rptr_q];
    assign count = cnt_q;

endmodule

// File: rtl/ring_evt_buf.sv
// Circular sample buffer: L1As queue a rewound start address, a readout FSM
// streams NSAMP samples per event with header/last framing under back-pressure.
module ring_evt_buf
    import ring_evt_pkg::*;
#(
    parameter int DATA_W   = 12,
    parameter int ADDR_W   = 12,
    parameter int TAG_W    = 24,
    parameter int LF_AW    = 4,
    parameter int WARN_LVL = 3328
) (
    input  logic              CLK,
    input  logic              RST_RESYNC,
    input  logic [6:0]        NSAMP,
    input  logic [6:0]        PRE_SMP,
    input  logic [DATA_W-1:0] WDATA,
    input  logic              WREN,
    input  logic              L1A,
    input  logic [TAG_W-1:0]  L1A_TAG,
    input  logic              DST_AFL,
    output logic [DATA_W-1:0] RDATA,
    output logic              DATA_PUSH,
    output logic [TAG_W-1:0]  EVT_TAG,
    output logic              EVT_PUSH,
    output logic              EVT_LAST,
    output logic [LF_AW:0]    L1A_PEND,
    output logic              WARN,
    output logic              OVF,
    output logic              L1A_DROP
);

    localparam int DEPTH = 2**ADDR_W;

    typedef struct packed {
        logic [ADDR_W-1:0] start;
        logic [TAG_W-1:0]  tag;
    } ent_t;

    logic [DATA_W-1:0] ram [DEPTH];
    logic [DATA_W-1:0] ram_rd_q;

    rd_state_e         state_q, state_d;
    logic [ADDR_W-1:0] wa_q, wa_d, rd_addr_q, rd_addr_d, pp;
    logic [ADDR_W:0]   occ;
    logic [6:0]        cnt_q, cnt_d, n_q, n_d;
    logic [TAG_W-1:0]  evt_tag_q, evt_tag_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              evt_push_q, evt_push_d, drop_q, drop_d, ovf_q, ovf_d;
    logic [RD_LAT-1:0] vld_pipe_q, vld_pipe_d, last_pipe_q, last_pipe_d;
    logic              issue, last_issue, fifo_pop, fifo_full, fifo_empty;
    ent_t              fifo_din, fifo_head;

    assign fifo_din.start = wa_q - ADDR_W'(PRE_SMP);
    assign fifo_din.tag   = L1A_TAG;

    ring_l1a_fifo #(.W(ADDR_W + TAG_W), .AW(LF_AW)) u_l1a_fifo (
        .clk   (CLK),
        .rst   (RST_RESYNC),
        .push  (L1A),
        .pop   (fifo_pop),
        .din   (fifo_din),
        .dout  (fifo_head),
        .count (L1A_PEND),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_comb begin
        state_d    = state_q;
        rd_addr_d  = rd_addr_q;
        cnt_d      = cnt_q;
        n_d        = n_q;
        evt_tag_d  = evt_tag_q;
        evt_push_d = 1'b0;
        issue      = 1'b0;
        last_issue = 1'b0;
        fifo_pop   = 1'b0;
        wa_d       = WREN ? wa_q + ADDR_W'(1) : wa_q;
        drop_d     = L1A && fifo_full;

        unique case (state_q)
            IDLE: if (!fifo_empty && !DST_AFL) state_d = HDR;
            HDR: begin
                fifo_pop   = 1'b1;
                rd_addr_d  = fifo_head.start;
                cnt_d      = 7'd0;
                n_d        = eff_nsamp(NSAMP);
                evt_tag_d  = fifo_head.tag;
                evt_push_d = 1'b1;
                state_d    = READ;
            end
            READ: begin
                // Never read the slot about to be written: wait for the writer.
                if (!DST_AFL && rd_addr_q != wa_q) begin
                    issue     = 1'b1;
                    rd_addr_d = rd_addr_q + ADDR_W'(1);
                    cnt_d     = cnt_q + 7'd1;
                    if (cnt_q == n_q - 7'd1) begin
                        last_issue = 1'b1;
                        state_d    = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // HDR still owns the head entry, so its start stays protected until READ.
        if (state_q == READ)  pp = rd_addr_q;
        else if (!fifo_empty) pp = fifo_head.start;
        else                  pp = wa_q;
        occ   = {1'b0, wa_q - pp};
        ovf_d = ovf_q || (WREN && occ == (ADDR_W+1)'(DEPTH - 1)
                          && (state_q != IDLE || !fifo_empty));

        vld_pipe_d  = {vld_pipe_q[RD_LAT-2:0], issue};
        last_pipe_d = {last_pipe_q[RD_LAT-2:0], last_issue};
        rdata_d     = vld_pipe_q[0] ? ram_rd_q : rdata_q;
    end

    always_ff @(posedge CLK) begin
        if (WREN)  ram[wa_q] <= WDATA;
        if (issue) ram_rd_q  <= ram[rd_addr_q];
    end

    always_ff @(posedge CLK or posedge RST_RESYNC) begin
        if (RST_RESYNC) begin
            state_q     <= IDLE;
            wa_q        <= '0;
            rd_addr_q   <= '0;
            cnt_q       <= '0;
            n_q         <= '0;
            evt_tag_q   <= '0;
            evt_push_q  <= 1'b0;
            drop_q      <= 1'b0;
            ovf_q       <= 1'b0;
            vld_pipe_q  <= '0;
            last_pipe_q <= '0;
            rdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            wa_q        <= wa_d;
            rd_addr_q   <= rd_addr_d;
            cnt_q       <= cnt_d;
            n_q         <= n_d;
            evt_tag_q   <= evt_tag_d;
            evt_push_q  <= evt_push_d;
            drop_q      <= drop_d;
            ovf_q       <= ovf_d;
            vld_pipe_q  <= vld_pipe_d;
            last_pipe_q <= last_pipe_d;
            rdata_q     <= rdata_d;
        end
    end

    assign RDATA     = rdata_q;
    assign DATA_PUSH = vld_pipe_q[RD_LAT-1];
    assign EVT_LAST  = last_pipe_q[RD_LAT-1];
    assign EVT_TAG   = evt_tag_q;
    assign EVT_PUSH  = evt_push_q;
    assign WARN      = (occ > (ADDR_W+1)'(WARN_LVL));
    assign OVF       = ovf_q;
    assign L1A_DROP  = drop_q;

endmodule

// File: tb/tb_ring_evt_buf.sv
// Randomised bench for ring_evt_buf: a shadow memory plus an event queue predict
// the exact output word stream (with framing) for each scenario.
module tb_ring_evt_buf;
    import ring_evt_pkg::*;

    logic        CLK = 1'b0, RST_RESYNC = 1'b1;
    logic [6:0]  NSAMP = '0, PRE_SMP = '0;
    logic [11:0] WDATA = '0;
    logic        WREN = 1'b0, L1A = 1'b0, DST_AFL = 1'b0;
    logic [23:0] L1A_TAG = '0;
    logic [11:0] RDATA;
    logic        DATA_PUSH, EVT_PUSH, EVT_LAST, WARN, OVF, L1A_DROP;
    logic [23:0] EVT_TAG;
    logic [4:0]  L1A_PEND;

    ring_evt_buf dut (
        .CLK(CLK), .RST_RESYNC(RST_RESYNC), .NSAMP(NSAMP), .PRE_SMP(PRE_SMP),
        .WDATA(WDATA), .WREN(WREN), .L1A(L1A), .L1A_TAG(L1A_TAG), .DST_AFL(DST_AFL),
        .RDATA(RDATA), .DATA_PUSH(DATA_PUSH), .EVT_TAG(EVT_TAG), .EVT_PUSH(EVT_PUSH),
        .EVT_LAST(EVT_LAST), .L1A_PEND(L1A_PEND), .WARN(WARN), .OVF(OVF), .L1A_DROP(L1A_DROP)
    );

    always #5 CLK = ~CLK;

    int errors = 0, checks = 0;

    // Reference model: what was written where, and which events are owed.
    logic [11:0] shadow [4096];
    int          wa_m = 0;
    l1a_ent_t    exp_ev[$];
    logic [12:0] exp_w[$];
    logic [23:0] exp_t[$];
    bit          afl_mode = 1'b0;
    int          cyc_n = 0;

    // Observed stream.
    logic [12:0] push_q[$];
    logic [23:0] tag_q[$];
    int          drop_cnt = 0, viol = 0, afl_run = 0;

    always @(negedge CLK) begin
        if (DST_AFL) afl_run++; else afl_run = 0;
        if (!RST_RESYNC) begin
            if (DATA_PUSH) begin
                push_q.push_back({EVT_LAST, RDATA});
                if (afl_run >= 3) viol++;
            end
            if (EVT_PUSH) tag_q.push_back(EVT_TAG);
            if (L1A_DROP) drop_cnt++;
        end
    end

    task automatic cyc(input bit wren, input logic [11:0] d, input bit l1a,
                       input logic [23:0] tag, input bit rec);
        l1a_ent_t e;
        if (afl_mode && (cyc_n % 5 == 0)) DST_AFL = ~DST_AFL;
        cyc_n++;
        WREN = wren; WDATA = d; L1A = l1a; L1A_TAG = tag;
        if (l1a && rec) begin
            e.start = 12'(wa_m - int'(PRE_SMP));
            e.tag   = tag;
            exp_ev.push_back(e);
        end
        if (wren) begin
            shadow[wa_m] = d;
            wa_m = (wa_m + 1) % 4096;
        end
        @(posedge CLK); #1;
        WREN = 1'b0; L1A = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(1'b0, 12'd0, 1'b0, 24'd0, 1'b0);
    endtask

    task automatic wr_rand(input int n);
        repeat (n) cyc(1'b1, 12'($urandom), 1'b0, 24'd0, 1'b0);
    endtask

    function automatic void build_exp(input int n);
        exp_w.delete(); exp_t.delete();
        foreach (exp_ev[k]) begin
            exp_t.push_back(exp_ev[k].tag);
            for (int i = 0; i < n; i++)
                exp_w.push_back({(i == n - 1), shadow[(int'(exp_ev[k].start) + i) % 4096]});
        end
        exp_ev.delete();
    endfunction

    task automatic drain(input int base, input int budget);
        int c = 0;
        while (push_q.size() - base < exp_w.size() && c < budget) begin
            idle(1); c++;
        end
        idle(8);
    endtask

    task automatic do_reset();
        RST_RESYNC = 1'b1; WREN = 1'b0; L1A = 1'b0; DST_AFL = 1'b0; afl_mode = 1'b0;
        repeat (3) @(posedge CLK);
        #1 RST_RESYNC = 1'b0;
        wa_m = 0;
        exp_ev.delete();
    endtask

    task automatic test_reset();
        RST_RESYNC = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        checks++;
        if ({DATA_PUSH, RDATA, EVT_LAST} !== 14'd0) begin
            errors++; $display("FAIL reset_data got push=%b rdata=%h last=%b want 0", DATA_PUSH, RDATA, EVT_LAST);
        end
        checks++;
        if ({EVT_PUSH, EVT_TAG} !== 25'd0) begin
            errors++; $display("FAIL reset_evt got push=%b tag=%h want 0", EVT_PUSH, EVT_TAG);
        end
        checks++;
        if ({L1A_PEND, WARN, OVF, L1A_DROP} !== 8'd0) begin
            errors++; $display("FAIL reset_status got pend=%0d warn=%b ovf=%b drop=%b want 0", L1A_PEND, WARN, OVF, L1A_DROP);
        end
    endtask

    task automatic test_basic();
        int b, bt;
        logic [12:0] g;
        do_reset();
        NSAMP = 7'd16; PRE_SMP = 7'd8;
        b = push_q.size(); bt = tag_q.size();
        for (int i = 0; i < 40; i++) cyc(1'b1, 12'(i), (i == 32), 24'hABC, 1'b1);
        build_exp(16);
        drain(b, 300);
        checks++;
        if (push_q.size() - b != 16) begin
            errors++; $display("FAIL basic_count got %0d want 16", push_q.size() - b);
        end
        for (int i = 0; i < exp_w.size(); i++) begin
            g = (b + i < push_q.size()) ? push_q[b + i] : 13'bx;
            checks++;
            if (g !== exp_w[i]) begin
                errors++; $display("FAIL basic_word[%0d] got last=%b data=%h want last=%b data=%h", i, g[12], g[11:0], exp_w[i][12], exp_w[i][11:0]);
            end
        end
        checks++;
        if (tag_q.size() - bt != 1 || tag_q[bt] !== 24'hABC) begin
            errors++; $display("FAIL basic_tag got n=%0d want tag abc", tag_q.size() - bt);
        end
        checks++;
        if (L1A_PEND !== 5'd0) begin
            errors++; $display("FAIL basic_pend got %0d want 0", L1A_PEND);
        end
    endtask

    task automatic test_wrap();
        int b, bt;
        logic [12:0] g;
        logic [23:0] t;
        do_reset();
        NSAMP = 7'd16; PRE_SMP = 7'd10;
        wr_rand(4099);
        b = push_q.size(); bt = tag_q.size();
        t = 24'($urandom);
        cyc(1'b0, 12'd0, 1'b1, t, 1'b1);
        wr_rand(20);
        build_exp(16);
        drain(b, 300);
        checks++;
        if (push_q.size() - b != 16) begin
            errors++; $display("FAIL wrap_count got %0d want 16", push_q.size() - b);
        end
        for (int i = 0; i < exp_w.size(); i++) begin
            g = (b + i < push_q.size()) ? push_q[b + i] : 13'bx;
            checks++;
            if (g !== exp_w[i]) begin
                errors++; $display("FAIL wrap_word[%0d] got last=%b data=%h want last=%b data=%h", i, g[12], g[11:0], exp_w[i][12], exp_w[i][11:0]);
            end
        end
        checks++;
        if (tag_q.size() - bt != 1 || tag_q[bt] !== t) begin
            errors++; $display("FAIL wrap_tag got n=%0d want tag %h", tag_q.size() - bt, t);
        end
    endtask

    task automatic test_fifo_full();
        int b, bt, d0;
        logic [12:0] g;
        logic [23:0] t;
        do_reset();
        DST_AFL = 1'b1; NSAMP = 7'd4; PRE_SMP = 7'd4;
        wr_rand(50);
        d0 = drop_cnt;
        for (int i = 0; i < 17; i++) begin
            t = 24'($urandom);
            cyc(1'b1, 12'($urandom), 1'b1, t, (i < 16));
        end
        idle(3);
        checks++;
        if (L1A_PEND !== 5'd16) begin
            errors++; $display("FAIL full_pend got %0d want 16", L1A_PEND);
        end
        checks++;
        if (drop_cnt - d0 != 1) begin
            errors++; $display("FAIL full_drop got %0d pulse cycles want 1", drop_cnt - d0);
        end
        b = push_q.size(); bt = tag_q.size();
        DST_AFL = 1'b0;
        build_exp(4);
        drain(b, 600);
        checks++;
        if (push_q.size() - b != 64) begin
            errors++; $display("FAIL full_count got %0d want 64", push_q.size() - b);
        end
        for (int i = 0; i < exp_w.size(); i++) begin
            g = (b + i < push_q.size()) ? push_q[b + i] : 13'bx;
            checks++;
            if (g !== exp_w[i]) begin
                errors++; $display("FAIL full_word[%0d] got last=%b data=%h want last=%b data=%h", i, g[12], g[11:0], exp_w[i][12], exp_w[i][11:0]);
            end
        end
        for (int k = 0; k < exp_t.size(); k++) begin
            checks++;
            if (bt + k >= tag_q.size() || tag_q[bt + k] !== exp_t[k]) begin
                errors++; $display("FAIL full_tag[%0d] got %h want %h", k, (bt + k < tag_q.size()) ? tag_q[bt + k] : 24'hx, exp_t[k]);
            end
        end
        checks++;
        if (L1A_PEND !== 5'd0) begin
            errors++; $display("FAIL full_pend_end got %0d want 0", L1A_PEND);
        end
    endtask

    task automatic test_backpressure();
        int b, bt, v0;
        logic [12:0] g;
        logic [23:0] t;
        do_reset();
        NSAMP = 7'd64; PRE_SMP = 7'd0;
        b = push_q.size(); bt = tag_q.size(); v0 = viol;
        cyc_n = 0; afl_mode = 1'b1;
        for (int i = 0; i < 300; i++) begin
            t = 24'($urandom);
            cyc(1'b1, 12'($urandom), (i == 100 || i == 150), t, 1'b1);
        end
        build_exp(64);
        drain(b, 3000);
        afl_mode = 1'b0; DST_AFL = 1'b0;
        idle(4);
        checks++;
        if (push_q.size() - b != 128) begin
            errors++; $display("FAIL bp_count got %0d want 128", push_q.size() - b);
        end
        for (int i = 0; i < exp_w.size(); i++) begin
            g = (b + i < push_q.size()) ? push_q[b + i] : 13'bx;
            checks++;
            if (g !== exp_w[i]) begin
                errors++; $display("FAIL bp_word[%0d] got last=%b data=%h want last=%b data=%h", i, g[12], g[11:0], exp_w[i][12], exp_w[i][11:0]);
            end
        end
        for (int k = 0; k < exp_t.size(); k++) begin
            checks++;
            if (bt + k >= tag_q.size() || tag_q[bt + k] !== exp_t[k]) begin
                errors++; $display("FAIL bp_tag[%0d] want %h", k, exp_t[k]);
            end
        end
        checks++;
        if (viol - v0 != 0) begin
            errors++; $display("FAIL bp_late_push got %0d pushes >2 cycles into DST_AFL want 0", viol - v0);
        end
    endtask

    task automatic test_stall();
        int b;
        logic [12:0] g;
        do_reset();
        NSAMP = 7'd8; PRE_SMP = 7'd0;
        b = push_q.size();
        wr_rand(10);
        cyc(1'b1, 12'($urandom), 1'b1, 24'h5A5A5A, 1'b1);
        for (int i = 0; i < 12; i++) begin
            wr_rand(1);
            idle(3);
        end
        build_exp(8);
        drain(b, 100);
        checks++;
        if (push_q.size() - b != 8) begin
            errors++; $display("FAIL stall_count got %0d want 8", push_q.size() - b);
        end
        for (int i = 0; i < exp_w.size(); i++) begin
            g = (b + i < push_q.size()) ? push_q[b + i] : 13'bx;
            checks++;
            if (g !== exp_w[i]) begin
                errors++; $display("FAIL stall_word[%0d] got last=%b data=%h want last=%b data=%h", i, g[12], g[11:0], exp_w[i][12], exp_w[i][11:0]);
            end
        end
    endtask

    task automatic test_ovf_reset();
        int b;
        do_reset();
        DST_AFL = 1'b1; PRE_SMP = 7'd0; NSAMP = 7'd64;
        cyc(1'b1, 12'($urandom), 1'b1, 24'h123456, 1'b0);
        wr_rand(3327);
        checks++;
        if (WARN !== 1'b0) begin
            errors++; $display("FAIL warn_at_3328 got %b want 0", WARN);
        end
        wr_rand(1);
        checks++;
        if (WARN !== 1'b1) begin
            errors++; $display("FAIL warn_at_3329 got %b want 1", WARN);
        end
        wr_rand(766);
        checks++;
        if (OVF !== 1'b0) begin
            errors++; $display("FAIL ovf_before_wrap got %b want 0", OVF);
        end
        wr_rand(1);
        checks++;
        if (OVF !== 1'b1) begin
            errors++; $display("FAIL ovf_on_wrap got %b want 1", OVF);
        end
        b = push_q.size();
        DST_AFL = 1'b0;
        wr_rand(20);
        checks++;
        if (push_q.size() - b == 0) begin
            errors++; $display("FAIL ovf_readout_started got 0 pushes want >0");
        end
        RST_RESYNC = 1'b1;
        #2;
        checks++;
        if ({DATA_PUSH, EVT_PUSH, EVT_LAST, OVF, WARN, L1A_PEND} !== 10'd0) begin
            errors++; $display("FAIL midreset_outputs got push=%b evt=%b last=%b ovf=%b warn=%b pend=%0d want 0",
                               DATA_PUSH, EVT_PUSH, EVT_LAST, OVF, WARN, L1A_PEND);
        end
        repeat (2) @(posedge CLK);
        #1 RST_RESYNC = 1'b0;
        wa_m = 0;
        b = push_q.size();
        wr_rand(30);
        checks++;
        if (push_q.size() - b != 0) begin
            errors++; $display("FAIL postreset_push got %0d want 0", push_q.size() - b);
        end
        checks++;
        if (OVF !== 1'b0) begin
            errors++; $display("FAIL postreset_ovf got %b want 0", OVF);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_wrap();
        test_fifo_full();
        test_backpressure();
        test_stall();
        test_ovf_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
